// File: rtl/writeback_arbiter.sv
// Arbitrates the single register-file write port between the ALU and the load unit,
// and keeps a per-register pending-write scoreboard that drives decode hazard flags.
module writeback_arbiter #(
    parameter int WORD_SIZE   = 32,
    parameter int NUM_REGS    = 32,
    parameter int INDEX_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [INDEX_WIDTH-1:0] issue_idx,
    output logic                   issue_ready,
    input  logic                   alu_valid,
    input  logic [INDEX_WIDTH-1:0] alu_idx,
    input  logic [WORD_SIZE-1:0]   alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [INDEX_WIDTH-1:0] mem_idx,
    input  logic [WORD_SIZE-1:0]   mem_data,
    output logic                   mem_ready,
    output logic                   rf_write_enable,
    output logic [INDEX_WIDTH-1:0] rf_write_idx,
    output logic [WORD_SIZE-1:0]   rf_write_data,
    input  logic [INDEX_WIDTH-1:0] read_idx_1,
    input  logic [INDEX_WIDTH-1:0] read_idx_2,
    output logic                   hazard_1,
    output logic                   hazard_2
);

    logic [NUM_REGS-1:0]    r_busy;
    logic                   r_rr_ptr;
    logic                   r_wr_en;
    logic [INDEX_WIDTH-1:0] r_wr_idx;
    logic [WORD_SIZE-1:0]   r_wr_data;

    logic                   w_alu_gnt;
    logic                   w_mem_gnt;
    logic                   w_any_gnt;
    logic                   w_dual;
    logic                   w_issue_ok;
    logic [INDEX_WIDTH-1:0] w_win_idx;
    logic [WORD_SIZE-1:0]   w_win_data;
    logic [NUM_REGS-1:0]    w_set;
    logic [NUM_REGS-1:0]    w_clr;

    // rr_ptr names the requester that wins the next dual-valid cycle (0 = ALU).
    always_comb begin
        w_alu_gnt  = reset & alu_valid & (~mem_valid | ~r_rr_ptr);
        w_mem_gnt  = reset & mem_valid & (~alu_valid | r_rr_ptr);
        w_any_gnt  = w_alu_gnt | w_mem_gnt;
        w_dual     = alu_valid & mem_valid;
        w_win_idx  = w_mem_gnt ? mem_idx  : alu_idx;
        w_win_data = w_mem_gnt ? mem_data : alu_data;
        w_issue_ok = reset & issue_valid & ~r_busy[issue_idx];

        w_set = '0;
        if (w_issue_ok && (issue_idx != '0)) begin
            w_set[issue_idx] = 1'b1;
        end
        w_clr = '0;
        if (r_wr_en) begin
            w_clr[r_wr_idx] = 1'b1;
        end
    end

    // Set is OR'ed in after the clear so a same-edge issue keeps the register pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy    <= '0;
            r_rr_ptr  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_data <= '0;
        end else begin
            r_busy  <= (r_busy & ~w_clr) | w_set;
            r_wr_en <= w_any_gnt && (w_win_idx != '0);
            if (w_dual) begin
                r_rr_ptr <= ~r_rr_ptr;
            end
            if (w_any_gnt) begin
                r_wr_idx  <= w_win_idx;
                r_wr_data <= w_win_data;
            end
        end
    end

    assign issue_ready     = w_issue_ok;
    assign alu_ready       = w_alu_gnt;
    assign mem_ready       = w_mem_gnt;
    assign rf_write_enable = r_wr_en;
    assign rf_write_idx    = r_wr_idx;
    assign rf_write_data   = r_wr_data;
    assign hazard_1        = reset & r_busy[read_idx_1] & (read_idx_1 != '0);
    assign hazard_2        = reset & r_busy[read_idx_2] & (read_idx_2 != '0);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, single writeback, round-robin,
// WAW stall, same-edge set/clear and index-0 handling.
module tb_writeback_arbiter;

    localparam int W  = 32;
    localparam int N  = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic [IW-1:0] issue_idx;
    logic          issue_ready;
    logic          alu_valid;
    logic [IW-1:0] alu_idx;
    logic [W-1:0]  alu_data;
    logic          alu_ready;
    logic          mem_valid;
    logic [IW-1:0] mem_idx;
    logic [W-1:0]  mem_data;
    logic          mem_ready;
    logic          rf_write_enable;
    logic [IW-1:0] rf_write_idx;
    logic [W-1:0]  rf_write_data;
    logic [IW-1:0] read_idx_1;
    logic [IW-1:0] read_idx_2;
    logic          hazard_1;
    logic          hazard_2;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_arbiter #(.WORD_SIZE(W), .NUM_REGS(N), .INDEX_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
        .alu_valid(alu_valid), .alu_idx(alu_idx), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_idx(mem_idx), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_write_enable(rf_write_enable), .rf_write_idx(rf_write_idx),
        .rf_write_data(rf_write_data),
        .read_idx_1(read_idx_1), .read_idx_2(read_idx_2),
        .hazard_1(hazard_1), .hazard_2(hazard_2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_idx = '0;
        alu_valid = 1'b0; alu_idx = '0; alu_data = '0;
        mem_valid = 1'b0; mem_idx = '0; mem_data = '0;
        read_idx_1 = '0; read_idx_2 = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        #2;
        issue_valid = 1'b1; issue_idx = 5'd3;
        alu_valid = 1'b1; alu_idx = 5'd3; alu_data = 32'h1;
        #1;
        n_checks++;
        if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", rf_write_enable); end
        n_checks++;
        if (rf_write_idx !== 5'd0 || rf_write_data !== 32'd0) begin
            n_fail++; $display("FAIL reset_idx_data: got %0d/%h want 0/0", rf_write_idx, rf_write_data);
        end
        n_checks++;
        if (issue_ready !== 1'b0 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got issue=%b alu=%b mem=%b want 0", issue_ready, alu_ready, mem_ready);
        end
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        alu_valid = 1'b1; alu_idx = 5'd3; alu_data = 32'hAAAA_0003;
        mem_valid = 1'b1; mem_idx = 5'd4; mem_data = 32'hBBBB_0004;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (alu_ready !== (k % 2 == 0) || mem_ready !== (k % 2 == 1)) begin
                n_fail++; $display("FAIL rr_grant_%0d: got alu=%b mem=%b want alu=%b mem=%b",
                                   k, alu_ready, mem_ready, (k % 2 == 0), (k % 2 == 1));
            end
            tick();
            n_checks++;
            if (rf_write_enable !== 1'b1 || rf_write_idx !== ((k % 2 == 0) ? 5'd3 : 5'd4) ||
                rf_write_data !== ((k % 2 == 0) ? 32'hAAAA_0003 : 32'hBBBB_0004)) begin
                n_fail++; $display("FAIL rr_write_%0d: got we=%b idx=%0d data=%h", k,
                                   rf_write_enable, rf_write_idx, rf_write_data);
            end
        end
        idle_inputs();
        tick();
        n_checks++;
        if (rf_write_enable !== 1'b0 || rf_write_idx !== 5'd4) begin
            n_fail++; $display("FAIL rr_idle: got we=%b idx=%0d want we=0 idx=4", rf_write_enable, rf_write_idx);
        end
    endtask

    task automatic test_single_writeback();
        issue_valid = 1'b1; issue_idx = 5'd5;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL sw_issue_ready: got %b want 1", issue_ready); end
        tick();
        issue_valid = 1'b0;
        read_idx_1 = 5'd5;
        alu_valid = 1'b1; alu_idx = 5'd5; alu_data = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (hazard_1 !== 1'b1) begin n_fail++; $display("FAIL sw_hazard_set: got %b want 1", hazard_1); end
        n_checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL sw_alu_ready: got alu=%b mem=%b want 1/0", alu_ready, mem_ready);
        end
        tick();
        alu_valid = 1'b0;
        n_checks++;
        if (rf_write_enable !== 1'b1 || rf_write_idx !== 5'd5 || rf_write_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sw_write: got we=%b idx=%0d data=%h want 1/5/deadbeef",
                               rf_write_enable, rf_write_idx, rf_write_data);
        end
        n_checks++;
        if (hazard_1 !== 1'b1) begin n_fail++; $display("FAIL sw_hazard_commit_cycle: got %b want 1", hazard_1); end
        tick();
        n_checks++;
        if (hazard_1 !== 1'b0 || rf_write_enable !== 1'b0 || rf_write_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL sw_after_commit: got haz=%b we=%b data=%h want 0/0/deadbeef",
                               hazard_1, rf_write_enable, rf_write_data);
        end
        idle_inputs();
    endtask

    task automatic test_waw_stall();
        issue_valid = 1'b1; issue_idx = 5'd7;
        tick();
        mem_valid = 1'b1; mem_idx = 5'd7; mem_data = 32'h0000_0777;
        #1;
        n_checks++;
        if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %b want 0", issue_ready); end
        n_checks++;
        if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL waw_mem_ready: got %b want 1", mem_ready); end
        tick();
        mem_valid = 1'b0;
        #1;
        n_checks++;
        if (issue_ready !== 1'b0 || rf_write_enable !== 1'b1) begin
            n_fail++; $display("FAIL waw_commit_cycle: got ready=%b we=%b want 0/1", issue_ready, rf_write_enable);
        end
        tick();
        n_checks++;
        if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL waw_release: got %b want 1", issue_ready); end
        idle_inputs();
        tick();
    endtask

    task automatic test_same_edge();
        alu_valid = 1'b1; alu_idx = 5'd9; alu_data = 32'h9999_0009;
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_idx = 5'd9;
        read_idx_1 = 5'd9; read_idx_2 = 5'd9;
        #1;
        n_checks++;
        if (issue_ready !== 1'b1 || rf_write_enable !== 1'b1 || rf_write_idx !== 5'd9) begin
            n_fail++; $display("FAIL se_setup: got ready=%b we=%b idx=%0d want 1/1/9",
                               issue_ready, rf_write_enable, rf_write_idx);
        end
        tick();
        issue_valid = 1'b0;
        #1;
        n_checks++;
        if (hazard_1 !== 1'b1 || hazard_2 !== 1'b1) begin
            n_fail++; $display("FAIL se_set_wins: got h1=%b h2=%b want 1/1", hazard_1, hazard_2);
        end
        tick();
        n_checks++;
        if (hazard_1 !== 1'b1) begin n_fail++; $display("FAIL se_persist: got %b want 1", hazard_1); end
        idle_inputs();
    endtask

    task automatic test_index_zero();
        mem_valid = 1'b1; mem_idx = 5'd0; mem_data = 32'h0000_1234;
        issue_valid = 1'b1; issue_idx = 5'd0;
        read_idx_1 = 5'd0;
        #1;
        n_checks++;
        if (mem_ready !== 1'b1 || issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL z_ready: got mem=%b issue=%b want 1/1", mem_ready, issue_ready);
        end
        tick();
        mem_valid = 1'b0; issue_valid = 1'b0;
        #1;
        n_checks++;
        if (rf_write_enable !== 1'b0) begin n_fail++; $display("FAIL z_no_write: got %b want 0", rf_write_enable); end
        n_checks++;
        if (hazard_1 !== 1'b0) begin n_fail++; $display("FAIL z_hazard: got %b want 0", hazard_1); end
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        issue_valid = 1'b1; issue_idx = 5'd12;
        tick();
        issue_valid = 1'b0;
        read_idx_1 = 5'd12;
        alu_valid = 1'b1; alu_idx = 5'd3; alu_data = 32'hCAFE_0003;
        mem_valid = 1'b1; mem_idx = 5'd4; mem_data = 32'hCAFE_0004;
        #1;
        n_checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0 || hazard_1 !== 1'b1) begin
            n_fail++; $display("FAIL ar_pre: got alu=%b mem=%b haz=%b want 1/0/1", alu_ready, mem_ready, hazard_1);
        end
        tick();
        mem_valid = 1'b0;
        n_checks++;
        if (rf_write_enable !== 1'b1) begin n_fail++; $display("FAIL ar_pending_write: got %b want 1", rf_write_enable); end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (rf_write_enable !== 1'b0 || rf_write_idx !== 5'd0 || rf_write_data !== 32'd0) begin
            n_fail++; $display("FAIL ar_drop: got we=%b idx=%0d data=%h want 0/0/0",
                               rf_write_enable, rf_write_idx, rf_write_data);
        end
        n_checks++;
        if (alu_ready !== 1'b0 || hazard_1 !== 1'b0) begin
            n_fail++; $display("FAIL ar_outputs: got alu=%b haz=%b want 0/0", alu_ready, hazard_1);
        end
        idle_inputs();
        #1;
        reset = 1'b1;
        tick();
        read_idx_1 = 5'd12;
        alu_valid = 1'b1; alu_idx = 5'd3; alu_data = 32'h1;
        mem_valid = 1'b1; mem_idx = 5'd4; mem_data = 32'h2;
        #1;
        n_checks++;
        if (hazard_1 !== 1'b0) begin n_fail++; $display("FAIL ar_busy_cleared: got %b want 0", hazard_1); end
        n_checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL ar_first_dual: got alu=%b mem=%b want 1/0", alu_ready, mem_ready);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_writeback();
        test_waw_stall();
        test_same_edge();
        test_index_zero();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
